// File: rtl/rainbow_rotator.sv
// -----------------------------------------------------------------------------
// rainbow_rotator
// Light-pattern sequencer for the Rainbow Lights display. The N_LIGHTS outputs
// advance one position every LIGHT_INTERVAL enabled clocks, either rotating
// (wrap end to end) or bouncing (reflecting at the ends). A new pattern can be
// loaded through a valid/ready handshake at any time after reset.
//
// Ports
//   clk          in   1         system clock, all state on posedge
//   reset        in   1         asynchronous, active-high reset
//   enable       in   1         1 = interval counter advances, 0 = pause
//   dir          in   1         0 = toward higher index, 1 = toward lower index
//   mode         in   1         0 = rotate, 1 = bounce
//   load_valid   in   1         pattern load request
//   load_pattern in   N_LIGHTS  pattern to load
//   load_ready   out  1         a load can be accepted this cycle
//   lights       out  N_LIGHTS  current pattern driven to the LEDs
//   step_pulse   out  1         one-cycle pulse while a freshly stepped pattern shows
//   bounce_dir   out  1         effective bounce direction (0 up, 1 down)
// -----------------------------------------------------------------------------
module rainbow_rotator #(
  parameter int                  N_LIGHTS       = 6,
  parameter int                  LIGHT_INTERVAL = 12_000_000,
  parameter logic [N_LIGHTS-1:0] INIT_PATTERN   = 6'b000111,
  localparam int                 CNT_W          = $clog2(LIGHT_INTERVAL) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                dir,
  input  logic                mode,
  input  logic                load_valid,
  input  logic [N_LIGHTS-1:0] load_pattern,
  output logic                load_ready,
  output logic [N_LIGHTS-1:0] lights,
  output logic                step_pulse,
  output logic                bounce_dir
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(LIGHT_INTERVAL - 1);
  localparam logic [CNT_W-1:0] COUNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0]    count;
  logic                mode_q;      // mode seen last cycle, detects the 0->1 edge

  logic                eff_dir;
  logic [N_LIGHTS-1:0] step_lights;
  logic                step_dir;
  logic [N_LIGHTS-1:0] shift_up;
  logic [N_LIGHTS-1:0] shift_down;

  logic                load_accept;
  logic                step_fire;
  logic [CNT_W-1:0]    count_nxt;
  logic [N_LIGHTS-1:0] lights_nxt;
  logic                bdir_nxt;
  logic                pulse_nxt;

  // Candidate pattern and direction if a step were applied this cycle.
  always_comb begin
    shift_up    = {lights[N_LIGHTS-2:0], 1'b0};
    shift_down  = {1'b0, lights[N_LIGHTS-1:1]};
    step_lights = lights;
    step_dir    = dir;
    // On the first bounce-mode cycle bounce_dir still holds last cycle's dir,
    // so the live dir input is the one to latch.
    if (mode_q) begin
      eff_dir = bounce_dir;
    end else begin
      eff_dir = dir;
    end
    if (!mode) begin
      step_dir = dir;
      if (!dir) begin
        step_lights = {lights[N_LIGHTS-2:0], lights[N_LIGHTS-1]};
      end else begin
        step_lights = {lights[0], lights[N_LIGHTS-1:1]};
      end
    end else if (!eff_dir) begin
      if (!lights[N_LIGHTS-1]) begin
        step_dir    = 1'b0;
        step_lights = shift_up;
      end else begin
        // Top end lit: reflect now and move down, unless both ends are lit.
        step_dir = 1'b1;
        if (!lights[0]) begin
          step_lights = shift_down;
        end else begin
          step_lights = lights;
        end
      end
    end else begin
      if (!lights[0]) begin
        step_dir    = 1'b1;
        step_lights = shift_down;
      end else begin
        step_dir = 1'b0;
        if (!lights[N_LIGHTS-1]) begin
          step_lights = shift_up;
        end else begin
          step_lights = lights;
        end
      end
    end
  end

  // Next-state selection: an accepted load overrides a coincident step.
  always_comb begin
    load_accept = load_valid && load_ready;
    step_fire   = enable && (count == LAST_COUNT);
    count_nxt   = count;
    lights_nxt  = lights;
    bdir_nxt    = bounce_dir;
    pulse_nxt   = 1'b0;
    if (load_accept) begin
      count_nxt  = {CNT_W{1'b0}};
      lights_nxt = load_pattern;
      bdir_nxt   = dir;
      pulse_nxt  = 1'b0;
    end else begin
      if (step_fire) begin
        count_nxt = {CNT_W{1'b0}};
      end else if (enable) begin
        count_nxt = count + COUNT_ONE;
      end else begin
        count_nxt = count;
      end
      if (step_fire) begin
        lights_nxt = step_lights;
        bdir_nxt   = step_dir;
        pulse_nxt  = 1'b1;
      end else begin
        lights_nxt = lights;
        bdir_nxt   = mode ? eff_dir : dir;
        pulse_nxt  = 1'b0;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= {CNT_W{1'b0}};
      lights     <= INIT_PATTERN;
      step_pulse <= 1'b0;
      bounce_dir <= 1'b0;
      load_ready <= 1'b0;
      mode_q     <= 1'b0;
    end else begin
      count      <= count_nxt;
      lights     <= lights_nxt;
      step_pulse <= pulse_nxt;
      bounce_dir <= bdir_nxt;
      load_ready <= 1'b1;
      mode_q     <= mode;
    end
  end

endmodule

// File: tb/tb_rainbow_rotator.sv
// -----------------------------------------------------------------------------
// tb_rainbow_rotator
// Directed bench for rainbow_rotator with N_LIGHTS=6, LIGHT_INTERVAL=4,
// INIT_PATTERN=6'b000111. Inputs change and outputs are sampled on the falling
// clock edge; expected values come from hand-computed tables.
// -----------------------------------------------------------------------------
module tb_rainbow_rotator;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       dir;
  logic       mode;
  logic       load_valid;
  logic [5:0] load_pattern;
  logic       load_ready;
  logic [5:0] lights;
  logic       step_pulse;
  logic       bounce_dir;

  int checks = 0;
  int errors = 0;

  // Expected patterns after each step.
  logic [5:0] rot_up   [0:6] = '{6'b000111, 6'b001110, 6'b011100, 6'b111000,
                                 6'b110001, 6'b100011, 6'b000111};
  logic [5:0] rot_down [0:2] = '{6'b000111, 6'b100011, 6'b110001};
  logic [5:0] bnc      [0:9] = '{6'b000011, 6'b000110, 6'b001100, 6'b011000,
                                 6'b110000, 6'b011000, 6'b001100, 6'b000110,
                                 6'b000011, 6'b000110};
  logic       bnc_dir  [0:9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  rainbow_rotator #(
    .N_LIGHTS      (6),
    .LIGHT_INTERVAL(4),
    .INIT_PATTERN  (6'b000111)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .dir         (dir),
    .mode        (mode),
    .load_valid  (load_valid),
    .load_pattern(load_pattern),
    .load_ready  (load_ready),
    .lights      (lights),
    .step_pulse  (step_pulse),
    .bounce_dir  (bounce_dir)
  );

  always #5 clk = ~clk;

  task automatic chk6(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset        = 1'b1;
    enable       = 1'b1;
    dir          = 1'b0;
    mode         = 1'b0;
    load_valid   = 1'b0;
    load_pattern = 6'b000000;

    // Reset state.
    #2;
    chk6("reset_lights", lights, 6'b000111);
    chk1("reset_pulse", step_pulse, 1'b0);
    chk1("reset_bdir", bounce_dir, 1'b0);
    chk1("reset_ready", load_ready, 1'b0);
    cyc(2);
    reset = 1'b0;

    // Rotate up from reset: step every 4th cycle.
    for (int k = 1; k <= 24; k++) begin
      cyc(1);
      chk6("rot_up_lights", lights, rot_up[k/4]);
      chk1("rot_up_pulse", step_pulse, (k % 4) == 0);
      if (k == 1) begin
        chk1("ready_after_release", load_ready, 1'b1);
      end else begin
        chk1("ready_stays", load_ready, 1'b1);
      end
    end

    // Rotate down from reset; bounce_dir follows dir in rotate mode.
    #2 reset = 1'b1;
    dir = 1'b1;
    cyc(1);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      chk6("rot_down_lights", lights, rot_down[k/4]);
      chk1("rot_down_ones", $countones(lights) == 3, 1'b1);
      chk1("rot_bdir_tracks", bounce_dir, 1'b1);
    end

    // Bounce mode through a load of 000011.
    mode         = 1'b1;
    dir          = 1'b0;
    load_valid   = 1'b1;
    load_pattern = 6'b000011;
    cyc(1);
    load_valid = 1'b0;
    chk6("bnc_load", lights, 6'b000011);
    chk1("bnc_load_bdir", bounce_dir, 1'b0);
    chk1("bnc_load_pulse", step_pulse, 1'b0);
    for (int k = 1; k <= 36; k++) begin
      cyc(1);
      chk6("bnc_lights", lights, bnc[k/4]);
      chk1("bnc_dir", bounce_dir, bnc_dir[k/4]);
      chk1("bnc_pulse", step_pulse, (k % 4) == 0);
    end

    // Pause at count 2: everything frozen, step lands 2 cycles after resume.
    mode = 1'b0;
    cyc(2);
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      chk6("pause_lights", lights, 6'b000110);
      chk1("pause_pulse", step_pulse, 1'b0);
    end
    enable = 1'b1;
    cyc(1);
    chk6("resume_1", lights, 6'b000110);
    chk1("resume_1_pulse", step_pulse, 1'b0);
    cyc(1);
    chk6("resume_2", lights, 6'b001100);
    chk1("resume_2_pulse", step_pulse, 1'b1);

    // Load in the step cycle wins over the step.
    cyc(3);
    chk6("pre_load", lights, 6'b001100);
    load_valid   = 1'b1;
    load_pattern = 6'b101010;
    cyc(1);
    load_valid = 1'b0;
    chk6("step_load_lights", lights, 6'b101010);
    chk1("step_load_pulse", step_pulse, 1'b0);
    cyc(3);
    chk6("after_load_hold", lights, 6'b101010);
    chk1("after_load_hold_pulse", step_pulse, 1'b0);
    cyc(1);
    chk6("after_load_step", lights, 6'b010101);
    chk1("after_load_step_pulse", step_pulse, 1'b1);

    // Asynchronous reset between edges, with a load pending.
    load_valid   = 1'b1;
    load_pattern = 6'b111111;
    #2 reset = 1'b1;
    #1;
    chk6("async_rst_lights", lights, 6'b000111);
    chk1("async_rst_pulse", step_pulse, 1'b0);
    chk1("async_rst_ready", load_ready, 1'b0);
    chk1("async_rst_bdir", bounce_dir, 1'b0);
    cyc(2);
    reset = 1'b0;
    chk1("ready_low_at_release", load_ready, 1'b0);
    cyc(1);
    load_valid = 1'b0;
    chk1("ready_high_after", load_ready, 1'b1);
    chk6("pending_load_dropped", lights, 6'b000111);
    cyc(3);
    chk6("post_rst_step", lights, 6'b001110);
    chk1("post_rst_step_pulse", step_pulse, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
